ikbd_key_matrix: RTL and testbench

//  Parametrised keyboard-matrix engine for the ikbd: queues decoded key make/break events
//  in an event FIFO and applies them to a ROWS x COLS key-state bitmap.

---
 rtl/ikbd_key_matrix.sv | 194 +++++++++++++++++++
 tb/tb_ikbd_key_matrix.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ikbd_key_matrix.sv
// ikbd_key_matrix
//   Keyboard-matrix engine for the ikbd. Decoded key make/break events are
//   queued in a small FIFO and applied one at a time to a ROWS x COLS
//   key-state bitmap. Every real key transition is held for HOLD_CYCLES
//   clocks before the next one is applied, so the 6301 scan loop cannot miss
//   a short tap. The bitmap is presented as active-low column data, ANDed
//   over all currently selected (active-low) rows.
//
//   Optional feature macro: IKBD_KEYMATRIX_OVF_EN
//     defined   -> sticky overflow flag on ovf, cleared by ovf_clr
//     undefined -> ovf tied low, ovf_clr ignored
//
// Ports
//   clk        in   system clock (2MHz ikbd clock)
//   res_n      in   asynchronous active-low reset
//   ev_valid   in   key event offered
//   ev_ready   out  FIFO can accept an event (not full)
//   ev_press   in   1 = make, 0 = break
//   ev_code    in   key index = row*COLS + col
//   all_up     in   synchronous clear: release all keys, flush FIFO, cancel hold
//   row_sel_n  in   active-low row selects from the CPU ports
//   col_out    out  active-low column data for the selected rows
//   busy       out  FIFO non-empty or hold counter running
//   ovf        out  sticky overflow flag
//   ovf_clr    in   clears ovf
module ikbd_key_matrix #(
    parameter int ROWS        = 15,
    parameter int COLS        = 8,
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 20000
) (
    input  logic                           clk,
    input  logic                           res_n,
    input  logic                           ev_valid,
    output logic                           ev_ready,
    input  logic                           ev_press,
    input  logic [$clog2(ROWS*COLS)-1:0]   ev_code,
    input  logic                           all_up,
    input  logic [ROWS-1:0]                row_sel_n,
    output logic [COLS-1:0]                col_out,
    output logic                           busy,
    output logic                           ovf,
    input  logic                           ovf_clr
);

    localparam int NKEYS = ROWS * COLS;
    localparam int CW    = $clog2(NKEYS);
    localparam int PW    = $clog2(DEPTH);
    localparam int HW    = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    // One extra bit so a full power-of-two matrix still compares correctly.
    localparam logic [CW:0]   NKEYS_W   = (CW + 1)'(NKEYS);
    localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(DEPTH);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [NKEYS-1:0]    keys_q, keys_d;
    logic [PW-1:0]       rd_q, rd_d;
    logic [PW-1:0]       wr_q, wr_d;
    logic [PW:0]         count_q, count_d;
    logic                ready_q;
    logic                busy_q;
    logic [CW:0]         mem_q [DEPTH];

    logic                doPush;
    logic                doPop;
    logic                headPress;
    logic [CW-1:0]       headCode;

    assign ev_ready  = ready_q;
    assign busy      = busy_q;
    assign doPush    = ev_valid && ready_q && !all_up;
    assign doPop     = (state_q == IDLE) && (count_q != '0);
    assign headPress = mem_q[rd_q][CW];
    assign headCode  = mem_q[rd_q][CW-1:0];

    // Next-state logic: hold countdown, head evaluation, FIFO bookkeeping.
    // all_up is applied last so it overrides any push/pop on the same edge.
    always_comb begin
        keys_d  = keys_q;
        hold_d  = hold_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;

        if (state_q == HOLD) begin
            hold_d = hold_q - HW'(1);
        end

        if (doPop) begin
            rd_d = rd_q + PW'(1);
            // Out-of-range codes and no-change events are dropped without a hold.
            if ({1'b0, headCode} < NKEYS_W) begin
                if (keys_q[headCode] != headPress) begin
                    keys_d[headCode] = headPress;
                    hold_d           = HOLD_LOAD;
                end
            end
        end

        if (doPush) begin
            wr_d = wr_q + PW'(1);
        end

        case ({doPush, doPop})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase

        if (all_up) begin
            keys_d  = '0;
            hold_d  = '0;
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end

        state_d = (hold_d != '0) ? HOLD : IDLE;
    end

    // Engine state, bitmap, FIFO pointers and registered status outputs.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            keys_q  <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            keys_q  <= keys_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            ready_q <= (count_d != FULL_CNT);
            busy_q  <= (count_d != '0) || (hold_d != '0);
        end
    end

    // FIFO storage needs no reset; only the pointers define its contents.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wr_q] <= {ev_press, ev_code};
        end
    end

    // Column readout: a pressed key pulls its column low in every selected row.
    always_comb begin
        col_out = '1;
        for (int r = 0; r < ROWS; r++) begin
            if (!row_sel_n[r]) begin
                for (int c = 0; c < COLS; c++) begin
                    if (keys_q[r*COLS + c]) begin
                        col_out[c] = 1'b0;
                    end
                end
            end
        end
    end

`ifdef IKBD_KEYMATRIX_OVF_EN
    logic ovf_q;

    // Sticky overflow: a rejected offer sets it, and setting beats clearing.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            ovf_q <= 1'b0;
        end else if (ev_valid && !ready_q) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = ovf_clr;
    assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_ikbd_key_matrix.sv
// tb_ikbd_key_matrix
//   Directed self-checking bench for ikbd_key_matrix with HOLD_CYCLES=4.
//   Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_ikbd_key_matrix;

    localparam int ROWS  = 15;
    localparam int COLS  = 8;
    localparam int DEPTH = 8;
    localparam int HOLD  = 4;

    logic              clk;
    logic              res_n;
    logic              ev_valid;
    logic              ev_ready;
    logic              ev_press;
    logic [6:0]        ev_code;
    logic              all_up;
    logic [ROWS-1:0]   row_sel_n;
    logic [COLS-1:0]   col_out;
    logic              busy;
    logic              ovf;
    logic              ovf_clr;

    int compared   = 0;
    int mismatched = 0;

`ifdef IKBD_KEYMATRIX_OVF_EN
    localparam logic [7:0] OVF_EXP = 8'd1;
`else
    localparam logic [7:0] OVF_EXP = 8'd0;
`endif

    ikbd_key_matrix #(
        .ROWS        (ROWS),
        .COLS        (COLS),
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk       (clk),
        .res_n     (res_n),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_press  (ev_press),
        .ev_code   (ev_code),
        .all_up    (all_up),
        .row_sel_n (row_sel_n),
        .col_out   (col_out),
        .busy      (busy),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    // 10ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the event interface for the next edge.
    task automatic applyStimulus(input logic valid, input logic press, input int code);
        ev_valid = valid;
        ev_press = press;
        ev_code  = 7'(code);
    endtask

    // Compare one observed value with its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %02h expected %02h", tag, observed, expected);
        end
    endtask

    initial begin
        res_n     = 1'b0;
        ev_valid  = 1'b0;
        ev_press  = 1'b0;
        ev_code   = '0;
        all_up    = 1'b0;
        ovf_clr   = 1'b0;
        row_sel_n = '1;

        // Reset values
        tick();
        checkOutput("rst ready", 8'(ev_ready), 8'd1);
        checkOutput("rst busy", 8'(busy), 8'd0);
        checkOutput("rst col", col_out, 8'hFF);
        checkOutput("rst ovf", 8'(ovf), 8'd0);
        row_sel_n = '0;
        #1;
        checkOutput("rst col allrows", col_out, 8'hFF);
        tick();
        res_n = 1'b1;
        tick();

        // Make then break of code 26, break held off by the hold window
        $display("[TB] make/break latency and hold");
        row_sel_n = ~(15'd1 << 3);
        applyStimulus(1'b1, 1'b1, 26);
        tick();
        checkOutput("t2 col before apply", col_out, 8'hFF);
        checkOutput("t2 busy queued", 8'(busy), 8'd1);
        applyStimulus(1'b1, 1'b0, 26);
        tick();
        applyStimulus(1'b0, 1'b0, 0);
        checkOutput("t2 col make", col_out, 8'hFB);
        repeat (4) tick();
        checkOutput("t2 col still held", col_out, 8'hFB);
        tick();
        checkOutput("t2 col break", col_out, 8'hFF);
        repeat (3) tick();
        checkOutput("t2 busy in hold", 8'(busy), 8'd1);
        tick();
        checkOutput("t2 busy clear", 8'(busy), 8'd0);

        // Fill the FIFO while the engine is holding; ev10 arrives when full
        $display("[TB] FIFO fill and overflow");
        row_sel_n = ~(15'd1 << 5);
        for (int k = 0; k <= 10; k++) begin
            applyStimulus(1'b1, 1'b1, 40 + k);
            tick();
            if (k == 0) checkOutput("t3 col e0", col_out, 8'hFF);
            if (k == 1) checkOutput("t3 col e1", col_out, 8'hFE);
            if (k == 5) checkOutput("t3 col e5", col_out, 8'hFE);
            if (k == 6) checkOutput("t3 col e6", col_out, 8'hFC);
            if (k == 8) checkOutput("t3 ready e8", 8'(ev_ready), 8'd1);
            if (k == 9) checkOutput("t3 ready e9", 8'(ev_ready), 8'd0);
        end
        applyStimulus(1'b0, 1'b0, 0);
        checkOutput("t3 ovf", 8'(ovf), OVF_EXP);
        checkOutput("t3 ready e10", 8'(ev_ready), 8'd0);
        checkOutput("t3 col e10", col_out, 8'hFC);
        tick();
        checkOutput("t3 col e11", col_out, 8'hF8);
        checkOutput("t3 ready e11", 8'(ev_ready), 8'd1);
        for (int k = 3; k <= 7; k++) begin
            repeat (4) tick();
            checkOutput("t3 col before apply", col_out, 8'(8'hFF << k));
            tick();
            checkOutput("t3 col after apply", col_out, 8'(8'hFF << (k + 1)));
        end
        row_sel_n = ~(15'd1 << 6);
        repeat (4) tick();
        checkOutput("t3 row6 e40", col_out, 8'hFF);
        tick();
        checkOutput("t3 row6 e41", col_out, 8'hFE);
        repeat (4) tick();
        checkOutput("t3 row6 e45", col_out, 8'hFE);
        tick();
        checkOutput("t3 row6 e46", col_out, 8'hFC);
        repeat (5) tick();
        checkOutput("t3 rejected not applied", col_out, 8'hFC);
        checkOutput("t3 busy drained", 8'(busy), 8'd0);
        checkOutput("t3 ovf sticky", 8'(ovf), OVF_EXP);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checkOutput("t3 ovf cleared", 8'(ovf), 8'd0);

        // Out-of-range code is dropped without inserting a hold
        $display("[TB] out-of-range drop");
        row_sel_n = ~15'd1;
        applyStimulus(1'b1, 1'b1, 120);
        tick();
        applyStimulus(1'b1, 1'b1, 0);
        tick();
        applyStimulus(1'b0, 1'b0, 0);
        checkOutput("t4 col after drop", col_out, 8'hFF);
        checkOutput("t4 busy", 8'(busy), 8'd1);
        tick();
        checkOutput("t4 code0 applied", col_out, 8'hFE);
        all_up = 1'b1;
        tick();
        all_up = 1'b0;
        checkOutput("t4 all_up col", col_out, 8'hFF);
        checkOutput("t4 all_up busy", 8'(busy), 8'd0);

        // Two rows selected, then all_up during hold beats a simultaneous push
        $display("[TB] multi-row select and all_up");
        row_sel_n = ~(15'd1 << 1);
        applyStimulus(1'b1, 1'b1, 1);
        tick();
        applyStimulus(1'b1, 1'b1, 9);
        tick();
        applyStimulus(1'b0, 1'b0, 0);
        repeat (4) tick();
        checkOutput("t5 row1 before", col_out, 8'hFF);
        tick();
        checkOutput("t5 row1 after", col_out, 8'hFD);
        row_sel_n = ~15'd3;
        #1;
        checkOutput("t5 rows01", col_out, 8'hFD);
        tick();
        all_up = 1'b1;
        applyStimulus(1'b1, 1'b1, 2);
        tick();
        all_up = 1'b0;
        applyStimulus(1'b0, 1'b0, 0);
        checkOutput("t5 all_up col", col_out, 8'hFF);
        checkOutput("t5 all_up busy", 8'(busy), 8'd0);
        checkOutput("t5 all_up ready", 8'(ev_ready), 8'd1);
        repeat (6) tick();
        checkOutput("t5 push discarded", col_out, 8'hFF);
        checkOutput("t5 busy idle", 8'(busy), 8'd0);

        // Redundant make is dropped; the event behind it applies next cycle
        $display("[TB] redundant event drop");
        row_sel_n = ~15'd1;
        applyStimulus(1'b1, 1'b1, 3);
        tick();
        applyStimulus(1'b0, 1'b0, 0);
        tick();
        checkOutput("t6 code3 applied", col_out, 8'hF7);
        repeat (5) tick();
        applyStimulus(1'b1, 1'b1, 3);
        tick();
        applyStimulus(1'b0, 1'b0, 0);
        checkOutput("t6 dup busy", 8'(busy), 8'd1);
        tick();
        checkOutput("t6 dup busy clear", 8'(busy), 8'd0);
        checkOutput("t6 dup col", col_out, 8'hF7);
        applyStimulus(1'b1, 1'b1, 3);
        tick();
        applyStimulus(1'b1, 1'b1, 4);
        tick();
        applyStimulus(1'b0, 1'b0, 0);
        checkOutput("t6 dup dropped", col_out, 8'hF7);
        checkOutput("t6 follower queued", 8'(busy), 8'd1);
        tick();
        checkOutput("t6 follower applied", col_out, 8'hE7);

        // Asynchronous reset mid-hold with three events queued
        $display("[TB] async reset mid-hold");
        row_sel_n = '0;
        applyStimulus(1'b1, 1'b1, 100);
        tick();
        applyStimulus(1'b1, 1'b1, 101);
        tick();
        applyStimulus(1'b1, 1'b1, 102);
        tick();
        applyStimulus(1'b0, 1'b0, 0);
        checkOutput("t1 busy before", 8'(busy), 8'd1);
        #2;
        res_n = 1'b0;
        #1;
        checkOutput("t1 ready", 8'(ev_ready), 8'd1);
        checkOutput("t1 busy", 8'(busy), 8'd0);
        checkOutput("t1 col allrows", col_out, 8'hFF);
        row_sel_n = ~15'd1;
        #1;
        checkOutput("t1 col row0", col_out, 8'hFF);
        tick();
        res_n = 1'b1;
        repeat (10) tick();
        row_sel_n = '0;
        #1;
        checkOutput("t1 queue flushed col", col_out, 8'hFF);
        checkOutput("t1 queue flushed busy", 8'(busy), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
